// File: rtl/blob_seq_streamer.sv
// Thresholds a grayscale camera stream into one raster-ordered binary frame for Blob.
// Define THRESH_HYST_EN to enable per-row hysteresis thresholding.
module blob_seq_streamer #(
  parameter int IMG_COL = 640,
  parameter int IMG_ROW = 480,
  parameter int PIX_W   = 8,
  parameter int CNT_W   = 19
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_arm,
  input  logic             i_pix_valid,
  input  logic             i_sof,
  input  logic [PIX_W-1:0] i_gray,
  input  logic [PIX_W-1:0] i_thresh,
  input  logic [PIX_W-1:0] i_thresh_lo,
  input  logic             i_blob_done,
  output logic             o_valid,
  output logic             o_seq,
  output logic             o_busy,
  output logic             o_pad_err,
  output logic [7:0]       o_frame_cnt,
  output logic [2:0]       o_dbg_state
);

  // Handshake: o_valid is a one-cycle qualifier for o_seq with no ready; the
  // receiver must take every pixel presented. Gaps between pulses are allowed.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SOF = 3'd1,
    STREAM   = 3'd2,
    PAD      = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMG_COL * IMG_ROW - 1);

  state_t           state;
  logic [CNT_W-1:0] pix_cnt;  // index of the next pixel to emit
  logic             last;
  logic             pix_seq;

  assign last        = (pix_cnt == LAST_PIX);
  assign o_busy      = (state != IDLE);
  assign o_dbg_state = state;

`ifdef THRESH_HYST_EN
  localparam int COL_W = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COL - 1);

  logic [COL_W-1:0] col_cnt;
  logic [COL_W-1:0] col_now;
  logic             accept;

  assign col_now = (state == STREAM) ? col_cnt : '0;
  assign accept  = i_pix_valid &&
                   ((state == WAIT_SOF && i_sof) || (state == STREAM && !(i_sof && !last)));

  // o_seq still holds the previous pixel of this row whenever col_now != 0.
  always_comb begin
    pix_seq = 1'b0;
    if (i_thresh_lo > i_thresh)     pix_seq = (i_gray >= i_thresh);
    else if (i_gray >= i_thresh)    pix_seq = 1'b1;
    else if (i_gray < i_thresh_lo)  pix_seq = 1'b0;
    else                            pix_seq = (col_now == '0) ? 1'b0 : o_seq;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_cnt <= '0;
    end else if (accept) begin
      col_cnt <= (col_now == COL_LAST) ? '0 : col_now + 1'b1;
    end
  end
`else
  logic unused_thresh_lo;
  assign unused_thresh_lo = ^i_thresh_lo;

  always_comb begin
    pix_seq = (i_gray >= i_thresh);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      o_valid     <= 1'b0;
      o_seq       <= 1'b0;
      o_pad_err   <= 1'b0;
      o_frame_cnt <= 8'd0;
    end else begin
      o_valid <= 1'b0;
      if (i_arm) o_pad_err <= 1'b0;
      case (state)
        IDLE: begin
          pix_cnt <= '0;
          if (i_arm) state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (i_pix_valid && i_sof) begin
            o_valid <= 1'b1;
            o_seq   <= pix_seq;
            if (last) begin
              state <= DRAIN;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
              state   <= STREAM;
            end
          end
        end
        STREAM: begin
          if (i_pix_valid) begin
            o_valid <= 1'b1;
            if (i_sof && !last) begin
              // Early SOF: this cycle becomes the first padding pixel.
              o_seq     <= 1'b0;
              o_pad_err <= 1'b1;
              pix_cnt   <= pix_cnt + 1'b1;
              state     <= PAD;
            end else begin
              o_seq <= pix_seq;
              if (last) state <= DRAIN;
              else      pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        PAD: begin
          o_valid <= 1'b1;
          o_seq   <= 1'b0;
          if (last) state <= DRAIN;
          else      pix_cnt <= pix_cnt + 1'b1;
        end
        DRAIN: begin
          if (i_blob_done) begin
            state       <= IDLE;
            o_frame_cnt <= o_frame_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blob_seq_streamer.sv
// Directed bench for blob_seq_streamer on an 8x4 frame; a queue holds the
// expected o_seq value and arrival cycle of every pulse.
module tb_blob_seq_streamer;
  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int NPIX = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst, arm, pix_valid, sof, blob_done;
  logic [7:0] gray, thresh, thresh_lo;
  logic       valid, seq, busy, pad_err;
  logic [7:0] frame_cnt;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  blob_seq_streamer #(.IMG_COL(COLS), .IMG_ROW(ROWS), .PIX_W(8), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_pix_valid(pix_valid), .i_sof(sof),
    .i_gray(gray), .i_thresh(thresh), .i_thresh_lo(thresh_lo), .i_blob_done(blob_done),
    .o_valid(valid), .o_seq(seq), .o_busy(busy), .o_pad_err(pad_err),
    .o_frame_cnt(frame_cnt), .o_dbg_state(dbg_state)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          pulses = 0;
  logic [17:0] exp_q[$];  // {any_time, cycle[15:0], seq}
  logic [7:0]  gray_a[NPIX];
  logic [NPIX-1:0] seq_log;
  int          m_col;
  logic        m_prev;
  logic [7:0]  exp_row;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every o_valid pulse pops one expected entry.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      logic [17:0] e;
      if (pulses < NPIX) seq_log[pulses] = seq;
      pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'd0, valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("seq", {31'd0, seq}, {31'd0, e[0]});
        if (!e[17]) chk("latency", {16'd0, cyc[15:0]}, {16'd0, e[16:1]});
      end
    end
  end

  function automatic logic model_seq(input logic [7:0] g);
`ifdef THRESH_HYST_EN
    if (thresh_lo > thresh) return g >= thresh;
    if (g >= thresh) return 1'b1;
    if (g < thresh_lo) return 1'b0;
    return (m_col == 0) ? 1'b0 : m_prev;
`else
    return g >= thresh;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pix_valid = 1'b0; sof = 1'b0; arm = 1'b0; blob_done = 1'b0;
  endtask

  task automatic drive_pix(input logic [7:0] g, input logic s, input bit push);
    tick();
    pix_valid = 1'b1; gray = g; sof = s;
    if (push) begin
      m_prev = model_seq(g);
      exp_q.push_back({1'b0, 16'(cyc + 1), m_prev});
      m_col = (m_col == COLS - 1) ? 0 : m_col + 1;
    end
  endtask

  task automatic wait_empty(input string tag);
    tick();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic send_frame(input bit gaps, input bit sof_last);
    m_col = 0; m_prev = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          blob_done = ($urandom_range(0, 3) == 0);
        end
      end
      drive_pix(gray_a[i], (i == 0) || (i == NPIX - 1 && sof_last), 1'b1);
    end
  endtask

  task automatic done_pulse();
    tick(); blob_done = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; pix_valid = 1'b0; sof = 1'b0; blob_done = 1'b0;
    gray = 8'd0; thresh = 8'd16; thresh_lo = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_seq", {31'd0, seq}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pad_err", {31'd0, pad_err}, 32'd0);
    chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    tick(); rst = 1'b0;

    // Full ramp frame, thresh 16: 16 zeros then 16 ones.
    tick(); arm = 1'b1;
    tick();
    chk("arm_state", {29'd0, dbg_state}, 32'd1);
    for (int i = 0; i < NPIX; i++) gray_a[i] = 8'(i);
    pulses = 0;
    send_frame(1'b0, 1'b0);
    wait_empty("ramp");
    chk("ramp_pulses", pulses, NPIX);
    chk("ramp_log", seq_log, 32'hFFFF_0000);
    chk("ramp_busy", {31'd0, busy}, 32'd1);

    // Arm while in DRAIN is ignored; no done for 50 cycles.
    tick(); arm = 1'b1;
    repeat (50) tick();
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_state", {29'd0, dbg_state}, 32'd4);
    chk("drain_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    done_pulse();
    chk("done_frame_cnt", {24'd0, frame_cnt}, 32'd1);
    chk("done_idle", {29'd0, dbg_state}, 32'd0);

    // Pixels before SOF are dropped; random frame with gaps.
    thresh = 8'($urandom_range(1, 254));
    thresh_lo = 8'($urandom_range(0, thresh));
    pulses = 0;
    tick(); arm = 1'b1;
    for (int i = 0; i < 3; i++) drive_pix(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    tick();
    tick();
    chk("pre_sof_pulses", pulses, 32'd0);
    for (int i = 0; i < NPIX; i++) gray_a[i] = 8'($urandom_range(0, 255));
    send_frame(1'b1, 1'b0);
    wait_empty("random");
    chk("random_pulses", pulses, NPIX);
    done_pulse();
    chk("random_frame_cnt", {24'd0, frame_cnt}, 32'd2);

    // Early SOF after 10 pixels: 22 zero pad pulses.
    pulses = 0;
    tick(); arm = 1'b1;
    m_col = 0; m_prev = 1'b0;
    for (int i = 0; i < 10; i++) drive_pix(gray_a[i], i == 0, 1'b1);
    drive_pix(gray_a[10], 1'b1, 1'b0);
    for (int i = 0; i < NPIX - 10; i++) exp_q.push_back({1'b1, 16'd0, 1'b0});
    wait_empty("pad");
    chk("pad_pulses", pulses, NPIX);
    chk("pad_err_set", {31'd0, pad_err}, 32'd1);
    chk("pad_state", {29'd0, dbg_state}, 32'd4);
    for (int i = 0; i < 4; i++) drive_pix(8'hFF, i == 0, 1'b0);
    tick();
    tick();
    chk("drain_ignores_input", pulses, NPIX);
    done_pulse();
    chk("pad_frame_cnt", {24'd0, frame_cnt}, 32'd3);
    chk("pad_err_sticky", {31'd0, pad_err}, 32'd1);
    arm = 1'b1;
    tick();
    chk("pad_err_cleared", {31'd0, pad_err}, 32'd0);
    chk("rearm_state", {29'd0, dbg_state}, 32'd1);

    // Reset in the middle of a stream.
    thresh = 8'd200; thresh_lo = 8'd40;
    m_col = 0; m_prev = 1'b0;
    for (int i = 0; i < 5; i++) drive_pix(gray_a[i], i == 0, 1'b1);
    tick(); rst = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_seq", {31'd0, seq}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("mid_rst_queue", exp_q.size(), 32'd0);
    rst = 1'b0;

    // Fresh frame after reset, SOF also on the last pixel.
    pulses = 0;
    tick(); arm = 1'b1;
    send_frame(1'b0, 1'b1);
    wait_empty("sof_last");
    chk("sof_last_pulses", pulses, NPIX);
    chk("sof_last_pad_err", {31'd0, pad_err}, 32'd0);
    chk("sof_last_state", {29'd0, dbg_state}, 32'd4);
    done_pulse();
    chk("sof_last_frame_cnt", {24'd0, frame_cnt}, 32'd1);

    // Row pattern with hi=100, lo=50.
    thresh = 8'd100; thresh_lo = 8'd50;
`ifdef THRESH_HYST_EN
    exp_row = 8'b0111_0011;
`else
    exp_row = 8'b0001_0001;
`endif
    gray_a[0] = 8'd120; gray_a[1] = 8'd80; gray_a[2] = 8'd40; gray_a[3] = 8'd80;
    gray_a[4] = 8'd110; gray_a[5] = 8'd60; gray_a[6] = 8'd60; gray_a[7] = 8'd30;
    for (int i = COLS; i < NPIX; i++) gray_a[i] = 8'($urandom_range(0, 255));
    pulses = 0;
    tick(); arm = 1'b1;
    send_frame(1'b1, 1'b0);
    wait_empty("row");
    chk("row_pulses", pulses, NPIX);
    chk("row_pattern", {24'd0, seq_log[7:0]}, {24'd0, exp_row});
    done_pulse();
    chk("row_frame_cnt", {24'd0, frame_cnt}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
